fact_mmio_ctrl: RTL and testbench
=================================

// Module: fact_mmio_ctrl
// PURPOSE
//  Memory-mapped controller that sequences the factorial accelerator for the pipelined MIPS SoC.
//  Sits on the CPU MEM-stage data bus (aluout/writedata/memwrite) next to data memory and GPIO.
//  Holds operand/result registers, issues the one-cycle start pulse and tracks done/error/timeout.
//  Its output drives the factorial_start/factorial_done pins of the core.
// PARAMETERS
//  BASE_ADDR      32'h0000_0800  block base; decode hit when addr[31:4]==BASE_ADDR[31:4]
//  N_WIDTH        4              operand width presented to the accelerator
//  TIMEOUT_CYCLES 64             max WAIT cycles before abort; legal range 2..2^16
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        asynchronous, active-low reset
//  addr         in   32       CPU byte address (MEM-stage aluout)
//  memwrite     in   1        CPU store strobe, qualified by decode hit
//  writedata    in   32       CPU store data
//  rd_hit       out  1        addr falls in block window; top level selects rdata
//  rdata        out  32       register read data, combinational from addr
//  fact_n       out  N_WIDTH  operand to accelerator, stable from START until next GO
//  fact_start   out  1        one-cycle start pulse
//  fact_done    in   1        accelerator completion pulse/level
//  fact_err     in   1        accelerator overflow flag, valid with fact_done
//  fact_result  in   32       accelerator result, valid with fact_done
//  irq          out  1        only when FACT_IRQ_EN defined
// BEHAVIOUR
//  Register map (offset addr[3:2]):
//   0x0 N      RW  [N_WIDTH-1:0]; write ignored while busy (START/WAIT)
//   0x4 CTRL   W: bit0=1 GO; R: {31'b0,busy}
//   0x8 STATUS RO {29'b0,timeout,err,done}; reads do not clear
//   0xC RESULT RO latched result; 0 after timeout
//  Reset: state=IDLE; N, RESULT, STATUS, counter = 0; fact_start=0, fact_n=0, irq=0.
//  FSM IDLE/START/WAIT/DONE:
//   IDLE|DONE --GO--> START: clear done/err/timeout, fact_n<=N.
//   START (1 cycle): fact_start=1 -> WAIT, counter=0.
//   WAIT: fact_done=1 -> latch RESULT/err, done=1 -> DONE.
//         else counter==TIMEOUT_CYCLES-1 -> timeout=1, done=1, RESULT=0 -> DONE; else counter++.
//  Latency: GO store at cycle t -> fact_start at t+1 -> earliest done flag at t+3.
//  GO during START/WAIT ignored; CTRL write with bit0=0 is a no-op.
//  fact_done ignored outside WAIT (stale pulses never latch).
//  fact_done and timeout in same cycle: done wins, timeout=0, RESULT=fact_result.
//  Writes to STATUS/RESULT ignored (except W1C under FACT_IRQ_EN).
//  rd_hit=0 -> rdata=0. Stores without hit have no effect.
//  reset_n low mid-operation: immediate return to reset values; no start pulse on release.
// CONFIGURATION
//  FACT_IRQ_EN defined: CTRL bit1 = irq_en (RW, reset 0); irq = done & irq_en (level);
//   store to STATUS with bit0=1 clears done (and irq); GO also clears.
//  FACT_IRQ_EN undefined: no irq port, CTRL bit1 reads 0, STATUS fully read-only.
// STRUCTURE
//  Shared package soc_mmio_pkg: register offsets, BASE_ADDR map of all SoC peripherals,
//   FSM state encoding (2-bit localparams), STATUS bit indices.
//  Sub-module cycle_timer: clear/enable counter with terminal-count flag for the WAIT timeout.
// TESTING
//  1 N=5, GO -> fact_start one pulse at t+1, fact_n=5; done with result 120 -> STATUS=0x1, RESULT=120.
//  2 N=13, GO, done with fact_err=1 -> STATUS=0x3, RESULT=fact_result as driven.
//  3 GO, never drive done, TIMEOUT_CYCLES=64 -> STATUS=0x5 after 64 WAIT cycles, RESULT=0.
//  4 GO + N=7 write while busy -> no second pulse, fact_n unchanged; done at cycle 63 with timeout -> STATUS=0x1.
//  5 reset_n low in WAIT -> all outputs 0, STATUS=0; stray fact_done in IDLE -> no latch.
//  6 FACT_IRQ_EN: irq_en=1, complete job -> irq=1; store STATUS=0x1 -> irq=0, done=0.

Source files
------------

// File: rtl/soc_mmio_pkg.sv
// soc_mmio_pkg: SoC peripheral address map, factorial-controller register offsets, FSM encoding and STATUS layout.
package soc_mmio_pkg;

  localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
  localparam logic [31:0] GPIO_BASE = 32'h0000_0700;
  localparam logic [31:0] FACT_BASE = 32'h0000_0800;

  localparam logic [1:0] OFF_N      = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RESULT = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int ST_DONE    = 0;
  localparam int ST_ERR     = 1;
  localparam int ST_TIMEOUT = 2;

  typedef struct packed {
    logic timeout;
    logic err;
    logic done;
  } status_t;

  // Every peripheral owns a 16-byte window.
  function automatic logic win_hit(input logic [31:0] a, input logic [31:0] base);
    return a[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: clearable, enabled up-counter flagging the last cycle of a LIMIT-cycle window.
module cycle_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= count + W'(1);
  end

  assign tc = count == W'(LIMIT - 1);

endmodule

// File: rtl/fact_mmio_ctrl.sv
// fact_mmio_ctrl: MMIO sequencer for the factorial accelerator (N/CTRL/STATUS/RESULT, start pulse, timeout).
// Optional FACT_IRQ_EN adds CTRL.irq_en, a level irq output and write-1-to-clear of STATUS.done.
module fact_mmio_ctrl
  import soc_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = FACT_BASE,
  parameter int          N_WIDTH        = 4,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        addr,
  input  logic               memwrite,
  input  logic [31:0]        writedata,
  output logic               rd_hit,
  output logic [31:0]        rdata,
  output logic [N_WIDTH-1:0] fact_n,
  output logic               fact_start,
  input  logic               fact_done,
  input  logic               fact_err,
  input  logic [31:0]        fact_result
`ifdef FACT_IRQ_EN
  ,
  output logic               irq
`endif
);

  logic [1:0]         state;
  logic [N_WIDTH-1:0] n_reg;
  logic [31:0]        result;
  status_t            st;
  logic [1:0]         off;
  logic               wr, busy, go, tc, irq_en;
  logic               unused_bits;

  assign off         = addr[3:2];
  assign rd_hit      = win_hit(addr, BASE_ADDR);
  assign wr          = memwrite & rd_hit;
  assign busy        = state == S_START || state == S_WAIT;
  assign go          = wr && off == OFF_CTRL && writedata[0] && !busy;
  assign fact_start  = state == S_START;
  assign unused_bits = ^{writedata, addr[1:0]};

  cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (fact_start),
    .en     (state == S_WAIT),
    .tc     (tc)
  );

`ifdef FACT_IRQ_EN
  logic st_clr;
  assign st_clr = wr && off == OFF_STATUS && writedata[0];
  assign irq    = st.done & irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_en <= 1'b0;
    else if (wr && off == OFF_CTRL) irq_en <= writedata[1];
  end
`else
  logic st_clr;
  assign st_clr = 1'b0;
  assign irq_en = 1'b0;
`endif

  always_comb begin
    rdata = !rd_hit ? 32'd0 :
            off == OFF_N      ? 32'(n_reg) :
            off == OFF_CTRL   ? {30'd0, irq_en, busy} :
            off == OFF_STATUS ? {29'd0, st} : result;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      n_reg  <= '0;
      result <= '0;
      st     <= '0;
      fact_n <= '0;
    end else begin
      if (wr && off == OFF_N && !busy) n_reg <= writedata[N_WIDTH-1:0];
      if (st_clr) st.done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: if (go) begin
          state  <= S_START;
          st     <= '0;
          fact_n <= n_reg;
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          // A completion landing on the terminal count takes priority over the timeout.
          if (fact_done) begin
            result <= fact_result;
            st     <= '{timeout: 1'b0, err: fact_err, done: 1'b1};
            state  <= S_DONE;
          end else if (tc) begin
            result <= '0;
            st     <= '{timeout: 1'b1, err: 1'b0, done: 1'b1};
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_mmio_ctrl.sv
// tb_fact_mmio_ctrl: directed stimulus with a queue-based scoreboard checked by an independent monitor.
module tb_fact_mmio_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0800;
  localparam logic [31:0] A_N = BASE + 32'h0, A_CTRL = BASE + 32'h4, A_STAT = BASE + 32'h8, A_RES = BASE + 32'hC;
  localparam int SEL_RDATA = 0, SEL_HIT = 1, SEL_FN = 2, SEL_START = 3, SEL_IRQ = 4;

  logic        clk = 0, reset_n = 0, memwrite = 0, fact_done = 0, fact_err = 0;
  logic [31:0] addr = 0, writedata = 0, fact_result = 0;
  logic        rd_hit, fact_start;
  logic [31:0] rdata;
  logic [3:0]  fact_n;
`ifdef FACT_IRQ_EN
  logic        irq;
`endif

  fact_mmio_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addr       (addr),
    .memwrite   (memwrite),
    .writedata  (writedata),
    .rd_hit     (rd_hit),
    .rdata      (rdata),
    .fact_n     (fact_n),
    .fact_start (fact_start),
    .fact_done  (fact_done),
    .fact_err   (fact_err),
    .fact_result(fact_result)
`ifdef FACT_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  string       q_name[$];
  int          q_sel[$];
  logic [31:0] q_exp[$];
  int          s_cyc[$];
  logic [3:0]  s_n[$];

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RDATA: return rdata;
      SEL_HIT:   return {31'd0, rd_hit};
      SEL_FN:    return {28'd0, fact_n};
      SEL_START: return {31'd0, fact_start};
`ifdef FACT_IRQ_EN
      SEL_IRQ:   return {31'd0, irq};
`endif
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: samples mid-low-phase, drains the scoreboard and checks every start pulse.
  initial forever begin
    @(negedge clk);
    #2;
    while (q_name.size() > 0) begin
      string nm;
      int sel;
      logic [31:0] e, got;
      nm = q_name.pop_front();
      sel = q_sel.pop_front();
      e = q_exp.pop_front();
      got = observe(sel);
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, e, cyc);
      end
    end
    if (fact_start === 1'b1) begin
      tests++;
      if (s_cyc.size() == 0) begin
        fails++;
        $display("FAIL start_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        int ec;
        logic [3:0] en;
        ec = s_cyc.pop_front();
        en = s_n.pop_front();
        if (ec != cyc || fact_n !== en) begin
          fails++;
          $display("FAIL start_pulse: got cycle %0d n %0d expected cycle %0d n %0d", cyc, fact_n, ec, en);
        end
      end
    end
  end

  task automatic chk(input string nm, input int sel, input logic [31:0] a, input logic [31:0] e);
    @(negedge clk);
    addr = a;
    q_name.push_back(nm);
    q_sel.push_back(sel);
    q_exp.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit exp_start, input logic [3:0] exp_n);
    @(negedge clk);
    addr = a;
    writedata = d;
    memwrite = 1;
    if (exp_start) begin
      s_cyc.push_back(cyc + 1);
      s_n.push_back(exp_n);
    end
    @(negedge clk);
    memwrite = 0;
  endtask

  task automatic done_pulse(input logic [31:0] r, input logic e);
    fact_done = 1;
    fact_result = r;
    fact_err = e;
    @(negedge clk);
    fact_done = 0;
    fact_err = 0;
    fact_result = 32'hA5A5_A5A5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_start", SEL_START, A_N, 0);
    chk("rst_fact_n", SEL_FN, A_N, 0);
    reset_n = 1;
    chk("rst_n", SEL_RDATA, A_N, 0);
    chk("rst_ctrl", SEL_RDATA, A_CTRL, 0);
    chk("rst_status", SEL_RDATA, A_STAT, 0);
    chk("rst_result", SEL_RDATA, A_RES, 0);
    chk("miss_rdata", SEL_RDATA, 32'h0000_0900, 0);
    chk("miss_hit", SEL_HIT, 32'h0000_0900, 0);
    chk("hit_flag", SEL_HIT, A_RES, 1);
    wr(32'h0000_1000, 9, 0, 0);
    chk("miss_store", SEL_RDATA, A_N, 0);

    // 1: N=5 -> 120
    wr(A_N, 5, 0, 0);
    chk("n_write", SEL_RDATA, A_N, 5);
    wr(A_CTRL, 1, 1, 5);
    @(negedge clk);
    done_pulse(120, 0);
    chk("t1_status", SEL_RDATA, A_STAT, 32'h1);
    chk("t1_result", SEL_RDATA, A_RES, 120);
    chk("t1_ctrl", SEL_RDATA, A_CTRL, 0);
    chk("t1_fact_n", SEL_FN, A_RES, 5);

    // 2: N=13 with overflow
    wr(A_N, 13, 0, 0);
    wr(A_CTRL, 1, 1, 13);
    @(negedge clk);
    done_pulse(32'hDEAD_BEEF, 1);
    chk("t2_status", SEL_RDATA, A_STAT, 32'h3);
    chk("t2_result", SEL_RDATA, A_RES, 32'hDEAD_BEEF);
    wr(A_CTRL, 0, 0, 0);
    chk("noop_ctrl", SEL_RDATA, A_CTRL, 0);
    chk("noop_status", SEL_RDATA, A_STAT, 32'h3);
    wr(A_STAT, 6, 0, 0);
    chk("ro_status", SEL_RDATA, A_STAT, 32'h3);
    wr(A_RES, 0, 0, 0);
    chk("ro_result", SEL_RDATA, A_RES, 32'hDEAD_BEEF);
`ifndef FACT_IRQ_EN
    wr(A_STAT, 1, 0, 0);
    chk("ro_status_b0", SEL_RDATA, A_STAT, 32'h3);
`endif

    // 3: timeout after 64 WAIT cycles
    wr(A_CTRL, 1, 1, 13);
    repeat (63) @(negedge clk);
    chk("t3_busy_last", SEL_RDATA, A_CTRL, 1);
    chk("t3_status", SEL_RDATA, A_STAT, 32'h5);
    chk("t3_result", SEL_RDATA, A_RES, 0);

    // 4: writes while busy ignored; done on terminal count beats timeout
    wr(A_CTRL, 1, 1, 13);
    wr(A_N, 7, 0, 0);
    wr(A_CTRL, 1, 0, 0);
    repeat (60) @(negedge clk);
    done_pulse(77, 0);
    chk("t4_status", SEL_RDATA, A_STAT, 32'h1);
    chk("t4_result", SEL_RDATA, A_RES, 77);
    chk("t4_n", SEL_RDATA, A_N, 13);
    chk("t4_fact_n", SEL_FN, A_N, 13);

    // 5: reset mid-WAIT, then stale done in IDLE
    wr(A_N, 3, 0, 0);
    wr(A_CTRL, 1, 1, 3);
    repeat (3) @(negedge clk);
    reset_n = 0;
    chk("t5_start", SEL_START, A_N, 0);
    chk("t5_fact_n", SEL_FN, A_N, 0);
    chk("t5_n", SEL_RDATA, A_N, 0);
    chk("t5_ctrl", SEL_RDATA, A_CTRL, 0);
    chk("t5_status", SEL_RDATA, A_STAT, 0);
    chk("t5_result", SEL_RDATA, A_RES, 0);
    reset_n = 1;
    repeat (4) @(negedge clk);
    done_pulse(55, 1);
    chk("t5_stale_status", SEL_RDATA, A_STAT, 0);
    chk("t5_stale_result", SEL_RDATA, A_RES, 0);

`ifdef FACT_IRQ_EN
    // 6: interrupt enable and W1C
    wr(A_N, 4, 0, 0);
    wr(A_CTRL, 3, 1, 4);
    @(negedge clk);
    done_pulse(24, 0);
    chk("t6_irq_set", SEL_IRQ, A_STAT, 1);
    chk("t6_ctrl", SEL_RDATA, A_CTRL, 2);
    wr(A_STAT, 1, 0, 0);
    chk("t6_irq_clr", SEL_IRQ, A_STAT, 0);
    chk("t6_status", SEL_RDATA, A_STAT, 0);
`endif

    repeat (3) @(negedge clk);
    tests++;
    if (s_cyc.size() != 0) begin
      fails++;
      $display("FAIL start_missing: got %0d pulses outstanding expected 0", s_cyc.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
